// File: rtl/stall_pkg.sv
// Shared types and defaults for the global stall controller.
package stall_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_FLUSH   = 2'd3
    } stall_state_e;

    localparam int DEF_NUM_STAGES    = 4;
    localparam int DEF_RELEASE_DELAY = 2;
    localparam int DEF_FLUSH_CYCLES  = 1;
    localparam int DEF_CNT_W         = 32;

endpackage

// File: rtl/stall_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module stall_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/stall_manager.sv
// Global stall/flush controller: merges buffer-full and backpressure into one
// registered stall with release hysteresis, a stretchable flush pulse and perf counters.
module stall_manager
    import stall_pkg::*;
#(
    parameter int NUM_STAGES    = DEF_NUM_STAGES,
    parameter int RELEASE_DELAY = DEF_RELEASE_DELAY,
    parameter int FLUSH_CYCLES  = DEF_FLUSH_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_STAGES-1:0] stage_full,
    input  logic                  sink_ready,
    input  logic                  flush_req,
    input  logic                  cnt_clear,
    output logic                  stall_out,
    output logic                  flush_out,
    output logic [STATE_W-1:0]    state_out,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      stall_events
);

    localparam int RCNT_W = (RELEASE_DELAY > 0) ? $clog2(RELEASE_DELAY + 1) : 1;
    localparam int FCNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [RCNT_W-1:0] REL_LOAD =
        RCNT_W'((RELEASE_DELAY > 0) ? RELEASE_DELAY - 1 : 0);
    localparam logic [FCNT_W-1:0] FLUSH_LOAD =
        FCNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    stall_state_e      state;
    logic [RCNT_W-1:0] rel_cnt;
    logic [FCNT_W-1:0] fl_cnt;
    logic              cond;
    logic              evt_inc;

    assign cond      = (|stage_full) | ~sink_ready;
    // Only a fresh RUN->STALL entry is an event; re-stalls out of RELEASE are not.
    assign evt_inc   = (state == ST_RUN) & ~flush_req & cond;
    assign state_out = state;

    // Outputs are set alongside every state change so they stay pure flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            stall_out <= 1'b0;
            flush_out <= 1'b0;
            rel_cnt   <= '0;
            fl_cnt    <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (flush_req) begin
                        state     <= ST_FLUSH;
                        flush_out <= 1'b1;
                        fl_cnt    <= FLUSH_LOAD;
                    end else if (cond) begin
                        state     <= ST_STALL;
                        stall_out <= 1'b1;
                    end
                end
                ST_STALL: begin
                    if (flush_req) begin
                        state     <= ST_FLUSH;
                        stall_out <= 1'b0;
                        flush_out <= 1'b1;
                        fl_cnt    <= FLUSH_LOAD;
                    end else if (!cond) begin
                        if (RELEASE_DELAY == 0) begin
                            state     <= ST_RUN;
                            stall_out <= 1'b0;
                        end else begin
                            state   <= ST_RELEASE;
                            rel_cnt <= REL_LOAD;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (flush_req) begin
                        state     <= ST_FLUSH;
                        stall_out <= 1'b0;
                        flush_out <= 1'b1;
                        fl_cnt    <= FLUSH_LOAD;
                    end else if (cond) begin
                        state <= ST_STALL;
                    end else if (rel_cnt == '0) begin
                        state     <= ST_RUN;
                        stall_out <= 1'b0;
                    end else begin
                        rel_cnt <= rel_cnt - 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_req) begin
                        fl_cnt <= FLUSH_LOAD;
                    end else if (fl_cnt == '0) begin
                        state     <= ST_RUN;
                        flush_out <= 1'b0;
                    end else begin
                        fl_cnt <= fl_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    stall_sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (stall_out),
        .count (stall_cycles)
    );

    stall_sat_counter #(.W(CNT_W)) u_evt_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (evt_inc),
        .count (stall_events)
    );

endmodule

// File: tb/tb_stall_manager.sv
// Random plus directed stimulus for stall_manager, checked against a timer-based model.
module tb_stall_manager;

    localparam int NS   = 4;
    localparam int RD   = 2;
    localparam int FC   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [NS-1:0] stage_full;
    logic          sink_ready;
    logic          flush_req;
    logic          cnt_clear;
    logic          stall_out;
    logic          flush_out;
    logic [1:0]    state_out;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] stall_events;

    int n_vec = 0;
    int n_err = 0;

    // Model: stalled flag, hold-off timer, remaining flush cycles, counters.
    bit m_stalled;
    bit m_rel;
    int m_hold;
    int m_frem;
    int m_cyc;
    int m_evt;

    stall_manager #(
        .NUM_STAGES    (NS),
        .RELEASE_DELAY (RD),
        .FLUSH_CYCLES  (FC),
        .CNT_W         (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stage_full   (stage_full),
        .sink_ready   (sink_ready),
        .flush_req    (flush_req),
        .cnt_clear    (cnt_clear),
        .stall_out    (stall_out),
        .flush_out    (flush_out),
        .state_out    (state_out),
        .stall_cycles (stall_cycles),
        .stall_events (stall_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_stalled = 0;
        m_rel     = 0;
        m_hold    = 0;
        m_frem    = 0;
        m_cyc     = 0;
        m_evt     = 0;
    endtask

    task automatic m_step();
        bit cond;
        bit was_stall;
        bit evt;
        cond      = (|stage_full) || !sink_ready;
        was_stall = m_stalled;
        evt       = 0;
        if (m_frem > 0) begin
            if (flush_req) m_frem = FC;
            else           m_frem--;
        end else if (flush_req) begin
            m_frem    = FC;
            m_stalled = 0;
            m_rel     = 0;
        end else if (!m_stalled) begin
            if (cond) begin
                m_stalled = 1;
                m_rel     = 0;
                m_hold    = RD;
                evt       = 1;
            end
        end else if (cond) begin
            m_rel  = 0;
            m_hold = RD;
        end else if (m_hold == 0) begin
            m_stalled = 0;
            m_rel     = 0;
        end else begin
            m_hold--;
            m_rel = 1;
        end
        if (cnt_clear)                     m_cyc = 0;
        else if (was_stall && m_cyc < CMAX) m_cyc++;
        if (cnt_clear)                     m_evt = 0;
        else if (evt && m_evt < CMAX)      m_evt++;
    endtask

    task automatic check_all();
        int exp_state;
        exp_state = (m_frem > 0) ? 3 : (m_stalled ? (m_rel ? 2 : 1) : 0);
        chk("stall_out",    32'(stall_out),    32'(m_stalled));
        chk("flush_out",    32'(flush_out),    32'(m_frem > 0));
        chk("state_out",    32'(state_out),    32'(exp_state));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_cyc));
        chk("stall_events", 32'(stall_events), 32'(m_evt));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall_out),    32'd0);
        chk({tag, "_flush"}, 32'(flush_out),    32'd0);
        chk({tag, "_state"}, 32'(state_out),    32'd0);
        chk({tag, "_cyc"},   32'(stall_cycles), 32'd0);
        chk({tag, "_evt"},   32'(stall_events), 32'd0);
    endtask

    // One clock: check current outputs, apply inputs, advance the model on the edge.
    task automatic cyc(input logic [NS-1:0] sf, input logic sr, input logic fr, input logic cc);
        @(negedge clk);
        check_all();
        stage_full = sf;
        sink_ready = sr;
        flush_req  = fr;
        cnt_clear  = cc;
        @(posedge clk);
        m_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b0;
        #1 chk_zero(tag);
        stage_full = '0;
        sink_ready = 1'b1;
        flush_req  = 1'b0;
        cnt_clear  = 1'b0;
        m_reset();
        @(negedge clk) reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        stage_full = '0;
        sink_ready = 1'b1;
        flush_req  = 1'b0;
        cnt_clear  = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        @(negedge clk) reset = 1'b1;
        idle(10);

        // single stall with hysteresis, counters cleared first
        cyc('0, 1'b1, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 3; i++) cyc(4'b0100, 1'b1, 1'b0, 1'b0);
        idle(6);
        @(negedge clk);
        chk("plan_stall_cycles", 32'(stall_cycles), 32'd5);
        chk("plan_stall_events", 32'(stall_events), 32'd1);

        // re-stall while releasing
        cyc('0, 1'b0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0, 1'b0);
        cyc('0, 1'b1, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0, 1'b0);
        idle(6);

        // flush beats stall, stall follows after flush
        cyc(4'b1111, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cyc(4'b1111, 1'b1, 1'b0, 1'b0);
        idle(6);

        // flush extension
        cyc('0, 1'b1, 1'b1, 1'b0);
        idle(1);
        cyc('0, 1'b1, 1'b1, 1'b0);
        idle(7);

        // saturation then clear while stalled
        for (int i = 0; i < 20; i++) cyc(4'b0001, 1'b1, 1'b0, 1'b0);
        cyc(4'b0001, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(4'b0001, 1'b1, 1'b0, 1'b0);
        idle(5);

        // asynchronous reset mid-stall and mid-flush
        for (int i = 0; i < 3; i++) cyc(4'b0010, 1'b1, 1'b0, 1'b0);
        async_reset("rst_stall");
        idle(2);
        cyc('0, 1'b1, 1'b1, 1'b0);
        async_reset("rst_flush");
        idle(2);

        // randomized phases with varying stall density
        for (int ph = 0; ph < 4; ph++) begin
            int pct;
            pct = 4 + ph * 8;
            for (int n = 0; n < 800; n++) begin
                logic [NS-1:0] sf;
                for (int b = 0; b < NS; b++) sf[b] = ($urandom_range(0, 99) < pct);
                cyc(sf,
                    $urandom_range(0, 99) >= pct,
                    $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 2);
            end
            idle(4);
        end

        @(negedge clk);
        check_all();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
